// File: rtl/rom_ctrl_pkg.sv
// rtl/rom_ctrl_pkg.sv - shared types and defaults for the ROM burst arbiter
package rom_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with advance strobe
module rr_arbiter2
    import rom_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    // ptr names the requester that wins a tie
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr == ID_REQ1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_REQ0;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[0] ? ID_REQ1 : ID_REQ0;
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin burst reader sharing one ROM between two requesters
module rom_burst_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] start0,
    input  logic [LEN_W-1:0]  len0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] start1,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    output logic              out_last,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [1:0]        grant;
    logic              arb_ptr;
    logic              grant_take;
    logic              load_word;
    logic              drain_done;
    logic              owner;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1, req0}),
        .advance (grant_take),
        .grant   (grant),
        .ptr     (arb_ptr)
    );

    // The pointer flips away from the winner at grant time and only moves in IDLE,
    // so during a burst the owner is always the requester it does not favour.
    assign owner = (arb_ptr == ID_REQ1) ? ID_REQ0 : ID_REQ1;
    assign busy  = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        load_word  = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    grant_take = 1'b1;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (!out_valid || out_ready) begin
                    load_word = 1'b1;
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rom_addr  <= '0;
            rem_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            gnt0 <= grant_take & grant[0];
            gnt1 <= grant_take & grant[1];
            if (grant_take) begin
                rom_addr <= grant[1] ? start1 : start0;
                rem_q    <= grant[1] ? len1 : len0;
            end
            if (load_word) begin
                out_valid <= 1'b1;
                out_data  <= rom_data;
                out_id    <= owner;
                out_last  <= (rem_q == '0);
                if (rem_q != '0) begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                    rem_q    <= rem_q - LEN_W'(1);
                end
            end
            if (drain_done) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - self-checking bench for rom_burst_arbiter
module tb_rom_burst_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       id;
        logic       last;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] start0 = '0, len0 = '0, start1 = '0, len1 = '0;
    logic       out_ready = 1'b1;
    logic       gnt0, gnt1, out_valid, out_id, out_last, busy;
    logic [7:0] rom_addr, rom_data, out_data;
    logic [7:0] rom [0:255];

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    rom_burst_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .start0    (start0),
        .len0      (len0),
        .gnt0      (gnt0),
        .req1      (req1),
        .start1    (start1),
        .len1      (len1),
        .gnt1      (gnt1),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    int    n_checks = 0;
    int    n_fail = 0;
    word_t exp_q[$];
    logic  exp_gnt_q[$];
    word_t got_q[$];
    int    hs_cyc[$];
    int    cyc = 0;
    int    gnt_cyc = 0;
    int    gnt_count = 0;
    int    stall_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event/timeout required none", name);
    endtask

    // Model: a granted burst yields ROM words start..start+len (8-bit wrap), last on the final one.
    task automatic expect_burst(input logic id, input logic [7:0] st, input logic [7:0] ln);
        word_t      w;
        logic [7:0] a;
        exp_gnt_q.push_back(id);
        for (int i = 0; i <= int'(ln); i++) begin
            a      = st + 8'(i);
            w.data = rom[a];
            w.id   = id;
            w.last = (i == int'(ln));
            exp_q.push_back(w);
        end
    endtask

    // Compare process: outputs are stable around the negedge; a handshake seen here completes at the next posedge.
    word_t      cmp_w;
    logic       cmp_gid;
    logic       stalled = 1'b0;
    logic [7:0] prev_data, prev_addr;
    logic       prev_id, prev_last;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                gnt_count++;
                gnt_cyc = cyc;
                check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
                if (exp_gnt_q.size() == 0) begin
                    report_fail("gnt_unexpected");
                end else begin
                    cmp_gid = exp_gnt_q.pop_front();
                    check("gnt_id", 32'(gnt1), 32'(cmp_gid));
                end
            end
            if (out_valid) check("busy_when_valid", 32'(busy), 32'd1);
            if (stalled) begin
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_id", 32'(out_id), 32'(prev_id));
                check("stall_last", 32'(out_last), 32'(prev_last));
                check("stall_addr", 32'(rom_addr), 32'(prev_addr));
                check("stall_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready) begin
                got_q.push_back('{data: out_data, id: out_id, last: out_last});
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    report_fail("word_unexpected");
                end else begin
                    cmp_w = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(cmp_w.data));
                    check("out_id", 32'(out_id), 32'(cmp_w.id));
                    check("out_last", 32'(out_last), 32'(cmp_w.last));
                end
            end
            stalled = out_valid && !out_ready;
            if (stalled) stall_count++;
            prev_data = out_data;
            prev_id   = out_id;
            prev_last = out_last;
            prev_addr = rom_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic id);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = id ? gnt1 : gnt0;
        end
        if (!seen) report_fail("gnt_timeout");
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) report_fail("idle_timeout");
        check("gnt_pending", 32'(exp_gnt_q.size()), 32'd0);
    endtask

    task automatic do_req(input logic id, input logic [7:0] st, input logic [7:0] ln);
        expect_burst(id, st, ln);
        tick();
        if (id) begin
            req1 = 1'b1; start1 = st; len1 = ln;
        end else begin
            req0 = 1'b1; start0 = st; len0 = ln;
        end
        wait_gnt(id);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] lit [0:5];
    int         base;
    logic       t3_done;
    int         t1_gnt;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'hA0; rom[8'h01] = 8'hB1; rom[8'h02] = 8'hC2;
        rom[8'h03] = 8'hD3; rom[8'h04] = 8'hE4; rom[8'h05] = 8'hF5;
        rom[8'hFE] = 8'h11; rom[8'hFF] = 8'h22;

        tick();
        tick();
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;

        // 1: six-word burst from 00
        got_q.delete(); hs_cyc.delete();
        do_req(1'b0, 8'h00, 8'd5);
        t1_gnt = gnt_cyc;
        wait_idle();
        lit[0] = 8'hA0; lit[1] = 8'hB1; lit[2] = 8'hC2; lit[3] = 8'hD3; lit[4] = 8'hE4; lit[5] = 8'hF5;
        check("t1_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            check("t1_lit_data", 32'(got_q[i].data), 32'(lit[i]));
            check("t1_lit_last", 32'(got_q[i].last), 32'(i == 5));
        end
        if (hs_cyc.size() >= 6) begin
            check("t1_latency", 32'(hs_cyc[0] - t1_gnt), 32'd1);
            check("t1_throughput", 32'(hs_cyc[5] - hs_cyc[0]), 32'd5);
        end else begin
            report_fail("t1_handshakes");
        end

        // 2: wrap across FF->00 on requester 1
        got_q.delete();
        do_req(1'b1, 8'hFE, 8'd2);
        wait_idle();
        lit[0] = 8'h11; lit[1] = 8'h22; lit[2] = 8'hA0;
        check("t2_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            check("t2_lit_data", 32'(got_q[i].data), 32'(lit[i]));
            check("t2_lit_id", 32'(got_q[i].id), 32'd1);
            check("t2_lit_last", 32'(got_q[i].last), 32'(i == 2));
        end

        // 3: both requesting from reset alternate strictly
        pulse_reset();
        got_q.delete();
        expect_burst(1'b0, 8'h00, 8'd0);
        expect_burst(1'b1, 8'hFE, 8'd0);
        expect_burst(1'b0, 8'h00, 8'd0);
        base = gnt_count;
        req0 = 1'b1; start0 = 8'h00; len0 = 8'd0;
        req1 = 1'b1; start1 = 8'hFE; len1 = 8'd0;
        t3_done = 1'b0;
        for (int k = 0; k < 60 && !t3_done; k++) begin
            @(negedge clk);
            #1;
            t3_done = (gnt_count >= base + 3);
        end
        if (!t3_done) report_fail("t3_gnt_timeout");
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
        check("t3_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("t3_w0", 32'({got_q[0].data, got_q[0].id}), 32'h140);
            check("t3_w1", 32'({got_q[1].data, got_q[1].id}), 32'h023);
            check("t3_w2", 32'({got_q[2].data, got_q[2].id}), 32'h140);
        end

        // 4: backpressure on the first word
        got_q.delete();
        base = stall_count;
        expect_burst(1'b0, 8'h01, 8'd3);
        tick();
        req0 = 1'b1; start0 = 8'h01; len0 = 8'd3;
        wait_gnt(1'b0);
        tick();
        req0 = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check("t4_addr_frozen", 32'(rom_addr), 32'h02);
        check("t4_held_word", 32'(out_data), 32'hB1);
        out_ready = 1'b1;
        wait_idle();
        check("t4_stalls", 32'(stall_count - base), 32'd3);
        lit[0] = 8'hB1; lit[1] = 8'hC2; lit[2] = 8'hD3; lit[3] = 8'hE4;
        check("t4_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            check("t4_lit_data", 32'(got_q[i].data), 32'(lit[i]));
        end

        // 5: reset mid-burst, then a fresh burst
        got_q.delete();
        expect_burst(1'b0, 8'h00, 8'd5);
        tick();
        req0 = 1'b1; start0 = 8'h00; len0 = 8'd5;
        wait_gnt(1'b0);
        tick();
        req0 = 1'b0;
        t3_done = 1'b0;
        for (int k = 0; k < 30 && !t3_done; k++) begin
            @(negedge clk);
            #1;
            t3_done = (got_q.size() >= 3);
        end
        if (!t3_done) report_fail("t5_word_timeout");
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_addr", 32'(rom_addr), 32'd0);
        check("t5_last", 32'(out_last), 32'd0);
        exp_q.delete();
        exp_gnt_q.delete();
        tick();
        rst_n = 1'b1;
        check("t5_abandoned", 32'(got_q.size()), 32'd3);
        got_q.delete();
        do_req(1'b0, 8'h04, 8'd1);
        wait_idle();
        check("t5_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t5_w0", 32'({got_q[0].data, got_q[0].last}), 32'h1C8);
            check("t5_w1", 32'({got_q[1].data, got_q[1].last}), 32'h1EB);
        end

        // 6: short req1 pulse during a req0 burst is ignored
        got_q.delete();
        base = gnt_count;
        expect_burst(1'b0, 8'h00, 8'd5);
        tick();
        req0 = 1'b1; start0 = 8'h00; len0 = 8'd5;
        wait_gnt(1'b0);
        tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b1; start1 = 8'h10; len1 = 8'd0;
        tick();
        req1 = 1'b0;
        wait_idle();
        repeat (5) tick();
        check("t6_gnt_count", 32'(gnt_count - base), 32'd1);
        check("t6_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size(); i++) begin
            check("t6_id", 32'(got_q[i].id), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
